// File: rtl/rx_packet_fifo_pkg.sv
// Shared defaults and types for the RX packet FIFO.
package usb_rx_pkg;

    localparam int RX_FIFO_DEPTH_DEF = 8;
    localparam int RX_DATA_W         = 8;

    typedef logic [RX_DATA_W-1:0] rx_byte_t;

endpackage : usb_rx_pkg

// File: rtl/rx_packet_fifo_ctrl.sv
// Pointer, occupancy, flag and error bookkeeping for the RX packet FIFO.
// RX_FIFO_STICKY_ERR_EN makes overflow/underflow hold until flush or reset.
module rx_fifo_ctrl #(
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = 6,
    parameter int PTR_W     = $clog2(DEPTH),
    parameter int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    output logic             push_ok,
    output logic             pop_ok,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_LVL);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             ovf_evt, udf_evt;

    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_C);
    assign almost_full = (count_q >= AFULL_C);

    // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
    assign pop_ok  = !flush && pop && !empty;
    assign push_ok = !flush && push && (!full || pop_ok);
    assign ovf_evt = !flush && push && full && !pop;
    assign udf_evt = !flush && pop && empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = ovf_evt;
        underflow_d = udf_evt;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
`ifdef RX_FIFO_STICKY_ERR_EN
            overflow_d  = overflow_q | ovf_evt;
            underflow_d = underflow_q | udf_evt;
`else
            overflow_d  = ovf_evt;
            underflow_d = udf_evt;
`endif
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign wr_ptr    = wr_ptr_q;
    assign rd_ptr    = rd_ptr_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule : rx_fifo_ctrl

// File: rtl/rx_packet_fifo.sv
// First-word-fall-through receive FIFO: storage array and head mux around rx_fifo_ctrl.
// Build option RX_FIFO_STICKY_ERR_EN (see rx_fifo_ctrl) makes error flags sticky.
module rx_packet_fifo
    import usb_rx_pkg::*;
#(
    parameter int DATA_W    = RX_DATA_W,
    parameter int DEPTH     = RX_FIFO_DEPTH_DEF,
    parameter int AFULL_LVL = 6
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     load_buffer,
    input  logic [DATA_W-1:0]        packet_data,
    input  logic                     read_en,
    input  logic                     flush,
    output logic [DATA_W-1:0]        rx_packet_data,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              push_ok, pop_ok;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    rx_fifo_ctrl #(
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL_LVL),
        .PTR_W     (PTR_W),
        .CNT_W     (CNT_W)
    ) u_ctrl (
        .clk         (clk),
        .n_rst       (n_rst),
        .push        (load_buffer),
        .pop         (read_en),
        .flush       (flush),
        .push_ok     (push_ok),
        .pop_ok      (pop_ok),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always_comb begin
        mem_d = mem_q;
        if (push_ok) mem_d[wr_ptr] = packet_data;
    end

    // Contents are qualified by count, so the array itself needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rx_packet_data = empty ? '0 : mem_q[rd_ptr];

endmodule : rx_packet_fifo

// File: tb/tb_rx_packet_fifo.sv
// Randomized and directed bench for rx_packet_fifo against a queue-based model.
module tb_rx_packet_fifo;

    localparam int DEPTH = 8;
    localparam int AFL   = 6;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       load_buffer = 1'b0;
    logic [7:0] packet_data = 8'h00;
    logic       read_en = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] rx_packet_data;
    logic       empty, full, almost_full, overflow, underflow;
    logic [3:0] count;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    byte unsigned q[$];
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;

    rx_packet_fifo #(.DATA_W(8), .DEPTH(DEPTH), .AFULL_LVL(AFL)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .load_buffer    (load_buffer),
        .packet_data    (packet_data),
        .read_en        (read_en),
        .flush          (flush),
        .rx_packet_data (rx_packet_data),
        .empty          (empty),
        .full           (full),
        .almost_full    (almost_full),
        .count          (count),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    always #5 clk = ~clk;

    // Reference behaviour: a plain queue with the priority rules applied per clock.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (flush) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            bit was_full, was_empty, oe, ue, popped;
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            oe = load_buffer && was_full && !read_en;
            ue = read_en && was_empty;
            popped = 1'b0;
            if (read_en && !was_empty) begin
                void'(q.pop_front());
                popped = 1'b1;
            end
            if (load_buffer && (!was_full || popped)) q.push_back(packet_data);
`ifdef RX_FIFO_STICKY_ERR_EN
            m_ovf = m_ovf | oe;
            m_udf = m_udf | ue;
`else
            m_ovf = oe;
            m_udf = ue;
`endif
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            int n;
            n = q.size();
            chk("m.count", int'(count), n);
            chk("m.empty", int'(empty), int'(n == 0));
            chk("m.full", int'(full), int'(n == DEPTH));
            chk("m.afull", int'(almost_full), int'(n >= AFL));
            chk("m.head", int'(rx_packet_data), (n > 0) ? int'(q[0]) : 0);
            chk("m.ovf", int'(overflow), int'(m_ovf));
            chk("m.udf", int'(underflow), int'(m_udf));
        end
    end

    // Apply one cycle of inputs; returns just after the following negedge.
    task automatic cyc(input bit p, input logic [7:0] d, input bit r, input bit f);
        load_buffer = p;
        packet_data = d;
        read_en     = r;
        flush       = f;
        @(negedge clk);
        #1;
        load_buffer = 1'b0;
        read_en     = 1'b0;
        flush       = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst.empty", int'(empty), 1);
        chk("rst.count", int'(count), 0);
        chk("rst.head", int'(rx_packet_data), 0);
        n_rst = 1'b1;
        chk_en = 1'b1;

        // Ordering
        cyc(1, 8'h11, 0, 0);
        cyc(1, 8'h22, 0, 0);
        cyc(1, 8'h33, 0, 0);
        chk("ord.count3", int'(count), 3);
        chk("ord.head11", int'(rx_packet_data), 8'h11);
        cyc(0, 0, 1, 0);
        chk("ord.head22", int'(rx_packet_data), 8'h22);
        cyc(0, 0, 1, 0);
        chk("ord.head33", int'(rx_packet_data), 8'h33);
        cyc(0, 0, 1, 0);
        chk("ord.empty", int'(empty), 1);
        chk("ord.count0", int'(count), 0);

        // Full and overflow
        for (int i = 0; i < 9; i++) begin
            cyc(1, 8'hA0 + 8'(i), 0, 0);
            if (i == 7) chk("ovf.full8", int'(full), 1);
        end
        chk("ovf.pulse", int'(overflow), 1);
        chk("ovf.count", int'(count), 8);
        cyc(0, 0, 0, 0);
`ifdef RX_FIFO_STICKY_ERR_EN
        chk("ovf.held", int'(overflow), 1);
`else
        chk("ovf.gone", int'(overflow), 0);
`endif
        for (int i = 0; i < 8; i++) begin
            chk("ovf.drain", int'(rx_packet_data), 8'hA0 + i);
            cyc(0, 0, 1, 0);
        end
        chk("ovf.empty", int'(empty), 1);

        // Simultaneous push+pop at full and at empty
        for (int i = 0; i < 8; i++) cyc(1, 8'hB0 + 8'(i), 0, 0);
        cyc(1, 8'hC0, 1, 0);
        chk("sim.fullcnt", int'(count), 8);
        chk("sim.head", int'(rx_packet_data), 8'hB1);
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0);
        chk("sim.last", int'(rx_packet_data), 8'hC0);
        cyc(0, 0, 1, 0);
        cyc(1, 8'hD0, 1, 0);
        chk("sim.ecount", int'(count), 1);
        chk("sim.udf", int'(underflow), 1);
        chk("sim.ehead", int'(rx_packet_data), 8'hD0);

        // almost_full threshold and flush
        for (int i = 0; i < 4; i++) cyc(1, 8'h50 + 8'(i), 0, 0);
        chk("af.5", int'(almost_full), 0);
        cyc(1, 8'h60, 0, 0);
        chk("af.6", int'(almost_full), 1);
        cyc(0, 0, 1, 0);
        chk("af.back5", int'(almost_full), 0);
        chk("fl.pre", int'(count), 5);
        cyc(1, 8'hEE, 0, 1);
        chk("fl.count", int'(count), 0);
        chk("fl.empty", int'(empty), 1);
        chk("fl.head", int'(rx_packet_data), 0);
        chk("fl.ovf", int'(overflow), 0);

        // Interleaved traffic for pointer wrap
        for (int i = 0; i < 20; i++)
            cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)), 0);
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 39) == 0));

        // Error flag persistence
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 9; i++) cyc(1, 8'(i), 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
`ifdef RX_FIFO_STICKY_ERR_EN
        chk("stk.held", int'(overflow), 1);
`else
        chk("stk.pulse", int'(overflow), 0);
`endif
        cyc(0, 0, 0, 1);
        chk("stk.clear", int'(overflow), 0);

        // Asynchronous reset mid-cycle with an overflow pending
        for (int i = 0; i < 9; i++) cyc(1, 8'h70 + 8'(i), 0, 0);
        chk("ar.pre", int'(overflow), 1);
        #2;
        n_rst = 1'b0;
        #1;
        chk("ar.empty", int'(empty), 1);
        chk("ar.count", int'(count), 0);
        chk("ar.head", int'(rx_packet_data), 0);
        chk("ar.ovf", int'(overflow), 0);
        chk("ar.udf", int'(underflow), 0);
        @(negedge clk);
        #1;
        n_rst = 1'b1;
        cyc(1, 8'h99, 0, 0);
        chk("ar.after", int'(rx_packet_data), 8'h99);
        cyc(0, 0, 0, 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_rx_packet_fifo
